// File: rtl/quiet_gap_sequencer.sv
// quiet_gap_sequencer: arbitrates two requesters and issues one-hot bursts on en,
// separated by quiet gaps of MIN_QUIET..MAX_QUIET all-zero cycles. MAX_QUIET==0
// selects continuous mode, where en is one-hot on every cycle outside reset.
// Optional feature macro: QGS_STATS_EN adds saturating filler/grant counters.
module quiet_gap_sequencer #(
    parameter int unsigned MIN_QUIET = 2,
    parameter int unsigned MAX_QUIET = 8,
    parameter int unsigned BURST_W   = 4,
    parameter int unsigned GAP_W     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         req,
    input  logic [BURST_W-1:0] burst_len,
    output logic [1:0]         en,
    output logic               filler,
    output logic               busy,
    output logic [GAP_W-1:0]   gap_cnt
`ifdef QGS_STATS_EN
    ,
    output logic [15:0]        filler_count,
    output logic [15:0]        grant_count
`endif
);

    localparam bit               CONT  = (MAX_QUIET == 0);
    localparam logic [GAP_W-1:0] MIN_G = GAP_W'(MIN_QUIET);
    localparam logic [GAP_W-1:0] MAX_G = GAP_W'(MAX_QUIET);

    if (!CONT && MIN_QUIET < 1) begin : g_bad_min
        $error("quiet_gap_sequencer: MIN_QUIET must be >= 1 in gapped mode");
    end
    if (!CONT && MAX_QUIET < MIN_QUIET) begin : g_bad_max
        $error("quiet_gap_sequencer: MAX_QUIET must be >= MIN_QUIET");
    end
    if ((MAX_QUIET >> GAP_W) != 0) begin : g_bad_gapw
        $error("quiet_gap_sequencer: GAP_W too narrow for MAX_QUIET");
    end
    if (BURST_W < 1) begin : g_bad_burstw
        $error("quiet_gap_sequencer: BURST_W must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_QUIET
    } state_t;

    state_t             state_q;
    logic [1:0]         en_q;
    logic               filler_q;
    logic               busy_q;
    logic [GAP_W-1:0]   gap_q;
    logic               rr_q;
    logic [BURST_W-1:0] rem_q;

    logic               any_req;
    logic               grant_ch;
    logic [BURST_W-1:0] len_eff;
    logic               rem_last;
    logic               norm_grant;
    logic               fill_grant;

    function automatic logic [1:0] onehot(input logic ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

    // Arbitration and decision-point evaluation for the current cycle
    always_comb begin
        any_req    = |req;
        grant_ch   = req[rr_q] ? rr_q : ~rr_q;
        len_eff    = (burst_len == '0) ? BURST_W'(1) : burst_len;
        rem_last   = (rem_q == BURST_W'(1));
        norm_grant = 1'b0;
        fill_grant = 1'b0;
        case (state_q)
            S_IDLE: begin
                norm_grant = any_req;
            end
            S_ACTIVE: begin
                if (rem_last && CONT) begin
                    norm_grant = any_req;
                    fill_grant = ~any_req;
                end
            end
            S_QUIET: begin
                norm_grant = (gap_q >= MIN_G) && any_req;
                fill_grant = !((gap_q >= MIN_G) && any_req) && (gap_q == MAX_G);
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= CONT ? S_ACTIVE : S_IDLE;
            en_q     <= CONT ? 2'b01 : 2'b00;
            filler_q <= 1'b0;
            busy_q   <= CONT;
            gap_q    <= '0;
            rr_q     <= 1'b0;
            rem_q    <= BURST_W'(1);
        end else if (norm_grant) begin
            state_q  <= S_ACTIVE;
            en_q     <= onehot(grant_ch);
            filler_q <= 1'b0;
            busy_q   <= 1'b1;
            gap_q    <= '0;
            rr_q     <= ~grant_ch;
            rem_q    <= len_eff;
        end else if (fill_grant) begin
            state_q  <= S_ACTIVE;
            filler_q <= 1'b1;
            busy_q   <= 1'b1;
            gap_q    <= '0;
            rem_q    <= BURST_W'(1);
            // Gapped fillers rotate via rr; continuous fillers keep the current channel.
            if (state_q == S_QUIET) begin
                en_q <= onehot(rr_q);
                rr_q <= ~rr_q;
            end
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ACTIVE: begin
                    if (rem_last) begin
                        state_q  <= S_QUIET;
                        en_q     <= 2'b00;
                        filler_q <= 1'b0;
                        busy_q   <= 1'b0;
                        gap_q    <= GAP_W'(1);
                    end else begin
                        rem_q <= rem_q - BURST_W'(1);
                    end
                end
                S_QUIET: begin
                    gap_q <= gap_q + GAP_W'(1);
                end
                default: begin
                    state_q  <= CONT ? S_ACTIVE : S_IDLE;
                    en_q     <= CONT ? 2'b01 : 2'b00;
                    filler_q <= 1'b0;
                    busy_q   <= CONT;
                    gap_q    <= '0;
                    rem_q    <= BURST_W'(1);
                end
            endcase
        end
    end

    assign en      = en_q;
    assign filler  = filler_q;
    assign busy    = busy_q;
    assign gap_cnt = gap_q;

`ifdef QGS_STATS_EN
    logic [15:0] fcnt_q;
    logic [15:0] gcnt_q;

    // Saturating counts of filler and normal grants since reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fcnt_q <= '0;
            gcnt_q <= '0;
        end else begin
            if (fill_grant && fcnt_q != '1) begin
                fcnt_q <= fcnt_q + 16'd1;
            end
            if (norm_grant && gcnt_q != '1) begin
                gcnt_q <= gcnt_q + 16'd1;
            end
        end
    end

    assign filler_count = fcnt_q;
    assign grant_count  = gcnt_q;
`endif

endmodule
